pll_phase_step_ctrl: RTL and testbench
======================================

// Module: pll_phase_step_ctrl
// PURPOSE
// - Upstream controller for the PLL dynamic phase-shift port. It turns one software/FSM request
//   ("shift counter N by S steps, up or down") into a sequence of PLL phase-step bursts.
// - Drives cntsel / num_phase_shifts / updn / phase_en and consumes phase_done and locked.
// - Runs in the PLL scanclk domain. PLL status inputs are asynchronous and are synchronised here.
// PARAMETERS
// - MAX_BURST   7     largest num_phase_shifts per burst (1..7, 3-bit field)
// - EN_HOLD     2     cycles phase_en is held high per burst (>=1)
// - GAP_CYCLES  4     idle cycles between phase_done and the next burst (>=0)
// - TIMEOUT     1023  watchdog limit in cycles; used only with PLL_PHASE_TIMEOUT_EN
// PORTS
// - scanclk           in   1   sole clock
// - rst               in   1   synchronous, active-high reset
// - req_valid         in   1   request valid
// - req_ready         out  1   high only in IDLE; accept = req_valid & req_ready
// - req_cntsel        in   5   target PLL counter
// - req_updn          in   1   1 = shift up, 0 = shift down
// - req_steps         in   16  total phase steps requested
// - pll_locked        in   1   PLL locked (async)
// - phase_done        in   1   PLL step-complete (async, active-high)
// - cntsel            out  5   to PLL
// - num_phase_shifts  out  3   to PLL
// - updn              out  1   to PLL
// - phase_en          out  1   to PLL
// - busy              out  1   high whenever state != IDLE
// - done              out  1   one-cycle pulse at end of every accepted request
// - err               out  1   sticky; cleared on next accept
// - steps_left        out  16  remaining steps of current request
// BEHAVIOUR
// - Reset: all outputs 0 (req_ready 0 while rst high); state IDLE; req_ready 1 the first cycle after rst falls.
// - pll_locked and phase_done pass 2-FF synchronisers (latency 2); phase_done acts on synced rising edge.
// - States: IDLE, WAIT_LOCK, ISSUE, WAIT_DONE, GAP, FIN.
// - IDLE: on accept latch req_cntsel/req_updn, steps_left<=req_steps, err<=0.
//   req_steps==0 -> FIN; else -> WAIT_LOCK.
// - WAIT_LOCK: wait for synced locked=1, then -> ISSUE.
// - ISSUE: burst=min(steps_left,MAX_BURST); on entry cntsel/updn/num_phase_shifts load and are held
//   unchanged until the next ISSUE; phase_en=1 for exactly EN_HOLD cycles, then -> WAIT_DONE.
// - WAIT_DONE: on phase_done edge steps_left<=steps_left-burst; result 0 -> FIN, else -> GAP.
//   phase_done edge outside WAIT_DONE is ignored.
// - GAP: count GAP_CYCLES (0 = pass through in one cycle) -> WAIT_LOCK.
// - FIN: done=1 for one cycle -> IDLE. No new accept until back in IDLE.
// - Lock loss (synced locked=0) in ISSUE or WAIT_DONE: phase_en<=0, err<=1, -> FIN (steps_left kept).
// - steps_left never underflows: burst <= steps_left by construction.
// - rst mid-operation: immediate return to reset values next cycle; in-flight PLL step is abandoned.
// CONFIGURATION
// - PLL_PHASE_TIMEOUT_EN defined: counter runs in WAIT_LOCK and WAIT_DONE, cleared on state entry;
//   reaching TIMEOUT cycles -> err<=1, phase_en<=0, -> FIN.
// - Not defined: no counter, block waits indefinitely in WAIT_LOCK / WAIT_DONE; TIMEOUT unused.
// TESTING
// - locked=1, req_steps=10, up, cntsel=3 -> two bursts num_phase_shifts 7 then 3, phase_en 2 cycles
//   each, cntsel=3, updn=1, one done pulse, steps_left=0, err=0.
// - req_steps=0 -> no phase_en, done pulses 2 cycles after accept (via FIN), err=0.
// - locked=0 at accept, raised 20 cycles later -> first phase_en exactly 3 cycles after locked rises.
// - locked dropped during WAIT_DONE of first burst of 10 -> err=1, done pulse, steps_left=10, req_ready=1.
// - macro on, TIMEOUT=15, phase_done held 0 -> err=1 and done 16 cycles after entering WAIT_DONE.
// - rst asserted during WAIT_DONE -> next cycle all outputs 0; req_ready=1 first cycle after rst falls.

Source files
------------

// File: rtl/pll_phase_step_ctrl.sv
// pll_phase_step_ctrl: splits one "shift counter N by S steps" request into
// PLL dynamic phase-shift bursts of at most MAX_BURST steps each.
//
// Ports (all in the scanclk domain, rst synchronous active-high):
//   req_valid/req_ready/req_cntsel/req_updn/req_steps : request handshake
//   pll_locked, phase_done : asynchronous PLL status, synchronised here
//   cntsel/num_phase_shifts/updn/phase_en : PLL phase-shift port
//   busy, done (1-cycle pulse), err (sticky), steps_left : status
//
// Optional macro PLL_PHASE_TIMEOUT_EN adds a TIMEOUT-cycle watchdog on
// WAIT_LOCK and WAIT_DONE; without it those states wait indefinitely.

module pll_phase_step_ctrl #(
   parameter int MAX_BURST  = 7,
   parameter int EN_HOLD    = 2,
   parameter int GAP_CYCLES = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic        scanclk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_cntsel,
   input  logic        req_updn,
   input  logic [15:0] req_steps,
   input  logic        pll_locked,
   input  logic        phase_done,
   output logic [4:0]  cntsel,
   output logic [2:0]  num_phase_shifts,
   output logic        updn,
   output logic        phase_en,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] steps_left
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_LOCK = 3'd1;
   localparam logic [2:0] ISSUE     = 3'd2;
   localparam logic [2:0] WAIT_DONE = 3'd3;
   localparam logic [2:0] GAP       = 3'd4;
   localparam logic [2:0] FIN       = 3'd5;

   // One shared counter times the enable hold, the gap and the watchdog;
   // it is sized for the largest of the three limits.
   localparam int BIG1 = (TIMEOUT > EN_HOLD) ? TIMEOUT : EN_HOLD;
   localparam int BIG  = (BIG1 > GAP_CYCLES) ? BIG1 : GAP_CYCLES;
   localparam int CW   = $clog2(BIG + 2);

   localparam logic [CW-1:0] HOLD_LAST = CW'(EN_HOLD - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES);
   localparam logic [CW-1:0] CNT_SAT   = '1;

   localparam logic [2:0]  MAX_B = 3'(MAX_BURST);
   localparam logic [15:0] MAX_W = 16'(MAX_BURST);

   logic [2:0]    state;
   logic [2:0]    state_n;
   logic [CW-1:0] cnt;

   logic          lock_m;
   logic          lock_s;
   logic          pd_m;
   logic          pd_s;
   logic          pd_q;
   logic          pd_rise;

   logic [4:0]    lat_cntsel;
   logic          lat_updn;

   logic          accept;
   logic          enter_issue;
   logic          leave_issue;
   logic          fault;
   logic          take_step;
   logic          tmo;
   logic [2:0]    burst;
   logic [15:0]   rem;

   // ---------------------------------------------------------------
   // Status synchronisers
   // ---------------------------------------------------------------
   always_ff @(posedge scanclk) begin
      if (rst) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
         pd_m   <= 1'b0;
         pd_s   <= 1'b0;
         pd_q   <= 1'b0;
      end else begin
         lock_m <= pll_locked;
         lock_s <= lock_m;
         pd_m   <= phase_done;
         pd_s   <= pd_m;
         pd_q   <= pd_s;
      end
   end

   assign pd_rise = pd_s & ~pd_q;

   // ---------------------------------------------------------------
   // Handshake and status
   // ---------------------------------------------------------------
   // Gated by rst so the port reads 0 throughout reset even though
   // the state register already holds IDLE.
   assign req_ready = (state == IDLE) & ~rst;
   assign accept    = req_valid & req_ready;
   assign busy      = (state != IDLE);

   // ---------------------------------------------------------------
   // Burst sizing
   // ---------------------------------------------------------------
   assign burst = (steps_left < MAX_W) ? steps_left[2:0] : MAX_B;

   // The loaded burst is never larger than steps_left, so no underflow.
   assign rem = steps_left - {13'd0, num_phase_shifts};

`ifdef PLL_PHASE_TIMEOUT_EN
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   assign tmo = (cnt == TO_LAST);
`else
   assign tmo = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_n   = state;
      fault     = 1'b0;
      take_step = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_n = (req_steps == 16'd0) ? FIN : WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_n = ISSUE;
            end else if (tmo) begin
               fault   = 1'b1;
               state_n = FIN;
            end
         end
         ISSUE: begin
            if (!lock_s) begin
               fault   = 1'b1;
               state_n = FIN;
            end else if (cnt == HOLD_LAST) begin
               state_n = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!lock_s) begin
               fault   = 1'b1;
               state_n = FIN;
            end else if (pd_rise) begin
               take_step = 1'b1;
               state_n   = (rem == 16'd0) ? FIN : GAP;
            end else if (tmo) begin
               fault   = 1'b1;
               state_n = FIN;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_n = WAIT_LOCK;
            end
         end
         FIN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign enter_issue = (state_n == ISSUE) && (state != ISSUE);
   assign leave_issue = (state == ISSUE) && (state_n != ISSUE);

   // ---------------------------------------------------------------
   // State, counter and control registers
   // ---------------------------------------------------------------
   always_ff @(posedge scanclk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         // Cleared on every state entry, saturates while parked.
         if (state_n != state) begin
            cnt <= '0;
         end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge scanclk) begin
      if (rst) begin
         lat_cntsel <= 5'd0;
         lat_updn   <= 1'b0;
      end else if (accept) begin
         lat_cntsel <= req_cntsel;
         lat_updn   <= req_updn;
      end
   end

   // PLL port fields load on ISSUE entry and then stay put until the
   // next burst, so the PLL sees stable selects around phase_en.
   always_ff @(posedge scanclk) begin
      if (rst) begin
         cntsel           <= 5'd0;
         updn             <= 1'b0;
         num_phase_shifts <= 3'd0;
         phase_en         <= 1'b0;
      end else if (enter_issue) begin
         cntsel           <= lat_cntsel;
         updn             <= lat_updn;
         num_phase_shifts <= burst;
         phase_en         <= 1'b1;
      end else if (leave_issue) begin
         phase_en         <= 1'b0;
      end
   end

   always_ff @(posedge scanclk) begin
      if (rst) begin
         steps_left <= 16'd0;
      end else if (accept) begin
         steps_left <= req_steps;
      end else if (take_step) begin
         steps_left <= rem;
      end
   end

   always_ff @(posedge scanclk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (accept) begin
         err <= 1'b0;
      end else if (fault) begin
         err <= 1'b1;
      end
   end

   always_ff @(posedge scanclk) begin
      if (rst) begin
         done <= 1'b0;
      end else begin
         done <= (state == FIN);
      end
   end

endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// tb_pll_phase_step_ctrl: table vectors, hand sequences and random requests
// against a burst-list model for pll_phase_step_ctrl.

module tb_pll_phase_step_ctrl;

   localparam int MAXB = 7;
   localparam int HOLD = 2;
`ifdef PLL_PHASE_TIMEOUT_EN
   localparam int LOCK_WAIT = 8;
`else
   localparam int LOCK_WAIT = 20;
`endif

   logic        scanclk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_cntsel;
   logic        req_updn;
   logic [15:0] req_steps;
   logic        pll_locked;
   logic        phase_done;
   logic [4:0]  cntsel;
   logic [2:0]  num_phase_shifts;
   logic        updn;
   logic        phase_en;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] steps_left;

   pll_phase_step_ctrl #(
      .MAX_BURST  (7),
      .EN_HOLD    (2),
      .GAP_CYCLES (4),
      .TIMEOUT    (15)
   ) dut (
      .scanclk          (scanclk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_cntsel       (req_cntsel),
      .req_updn         (req_updn),
      .req_steps        (req_steps),
      .pll_locked       (pll_locked),
      .phase_done       (phase_done),
      .cntsel           (cntsel),
      .num_phase_shifts (num_phase_shifts),
      .updn             (updn),
      .phase_en         (phase_en),
      .busy             (busy),
      .done             (done),
      .err              (err),
      .steps_left       (steps_left)
   );

   initial scanclk = 1'b0;
   always #5 scanclk = ~scanclk;

   int n_chk;
   int n_fail;

   // burst observations for the current request
   logic [2:0] obs_n[$];
   logic [4:0] obs_cs[$];
   logic       obs_ud[$];
   int         obs_len[$];
   logic       pe_prev;
   int         run_len;
   int         cyc;
   int         done_cnt;
   int         done_cyc;
   logic       pll_auto;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge scanclk);
      #1;
   endtask

   task automatic sample();
      if (phase_en && !pe_prev) begin
         obs_n.push_back(num_phase_shifts);
         obs_cs.push_back(cntsel);
         obs_ud.push_back(updn);
         run_len = 0;
      end
      if (phase_en) run_len++;
      if (!phase_en && pe_prev) obs_len.push_back(run_len);
      if (done) begin
         if (done_cnt == 0) done_cyc = cyc;
         done_cnt++;
      end
      pe_prev = phase_en;
   endtask

   task automatic step();
      tick();
      cyc++;
      sample();
   endtask

   task automatic start_req(input logic [4:0] cs, input logic u,
                            input logic [15:0] st);
      obs_n.delete();
      obs_cs.delete();
      obs_ud.delete();
      obs_len.delete();
      pe_prev  = 1'b0;
      run_len  = 0;
      done_cnt = 0;
      done_cyc = -1;
      req_cntsel = cs;
      req_updn   = u;
      req_steps  = st;
      req_valid  = 1'b1;
      check("ready_at_accept", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      cyc = 1;
      sample();
   endtask

   task automatic wait_done(input int budget);
      while (done_cnt == 0 && cyc < budget) step();
      check("done_seen", {31'd0, done_cnt != 0}, 32'd1);
   endtask

   task automatic wait_en_fall(input int budget);
      while (obs_len.size() == 0 && cyc < budget) step();
      check("en_fall_seen", {31'd0, obs_len.size() != 0}, 32'd1);
   endtask

   // PLL model: answers each phase_en with a delayed phase_done pulse
   initial begin
      int d;
      phase_done = 1'b0;
      forever begin
         @(posedge phase_en);
         if (pll_auto) begin
            d = $urandom_range(2, 6);
            repeat (d) @(posedge scanclk);
            #1 phase_done = 1'b1;
            repeat (3) @(posedge scanclk);
            #1 phase_done = 1'b0;
         end
      end
   end

   typedef struct {
      logic [4:0]  cs;
      logic        ud;
      logic [15:0] st;
      int          nb;
      int          last;
   } vec_t;

   vec_t vt[6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{5'd3,  1'b1, 16'd10, 2, 3};
      vt[1] = '{5'd17, 1'b0, 16'd7,  1, 7};
      vt[2] = '{5'd31, 1'b1, 16'd1,  1, 1};
      vt[3] = '{5'd0,  1'b0, 16'd14, 2, 7};
      vt[4] = '{5'd9,  1'b1, 16'd15, 3, 1};
      vt[5] = '{5'd4,  1'b0, 16'd0,  0, 0};

      n_chk      = 0;
      n_fail     = 0;
      pll_auto   = 1'b1;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_cntsel = 5'd0;
      req_updn   = 1'b0;
      req_steps  = 16'd0;
      pll_locked = 1'b1;

      // reset state
      repeat (3) tick();
      check("rst_outs", {cntsel, num_phase_shifts, updn, phase_en, busy,
                         done, err, steps_left}, 32'd0);
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", {31'd0, req_ready}, 32'd1);
      repeat (3) tick();

      // table vectors
      for (int i = 0; i < 6; i++) begin
         start_req(vt[i].cs, vt[i].ud, vt[i].st);
         wait_done(1000);
         check($sformatf("v%0d_nb", i), obs_n.size(), vt[i].nb);
         if (vt[i].nb > 0 && obs_n.size() > 0) begin
            check($sformatf("v%0d_last", i), {29'd0, obs_n[$]}, vt[i].last);
            check($sformatf("v%0d_cs", i), {27'd0, obs_cs[0]}, {27'd0, vt[i].cs});
            check($sformatf("v%0d_ud", i), {31'd0, obs_ud[0]}, {31'd0, vt[i].ud});
            check($sformatf("v%0d_len", i), obs_len[0], HOLD);
         end
         if (vt[i].st == 16'd0)
            check("zero_done_lat", done_cyc, 2);
         check($sformatf("v%0d_left", i), {16'd0, steps_left}, 32'd0);
         check($sformatf("v%0d_err", i), {31'd0, err}, 32'd0);
         check($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
         step();
         check($sformatf("v%0d_pulse", i), done_cnt, 1);
         repeat (4) tick();
      end

      // lock late: phase_en three cycles after locked rises
      pll_locked = 1'b0;
      repeat (4) tick();
      start_req(5'd6, 1'b1, 16'd3);
      repeat (LOCK_WAIT) step();
      check("lock_wait_no_en", obs_n.size(), 0);
      check("lock_wait_busy", {31'd0, busy}, 32'd1);
      pll_locked = 1'b1;
      step();
      check("lock_en_c1", {31'd0, phase_en}, 32'd0);
      step();
      check("lock_en_c2", {31'd0, phase_en}, 32'd0);
      step();
      check("lock_en_c3", {31'd0, phase_en}, 32'd1);
      wait_done(cyc + 200);
      check("lock_left", {16'd0, steps_left}, 32'd0);
      check("lock_err", {31'd0, err}, 32'd0);
      repeat (4) tick();

      // lock lost while waiting for phase_done
      pll_auto = 1'b0;
      start_req(5'd5, 1'b1, 16'd10);
      wait_en_fall(100);
      step();
      step();
      check("ld_waiting", {30'd0, busy, phase_en}, 32'd2);
      pll_locked = 1'b0;
      wait_done(cyc + 50);
      check("ld_err", {31'd0, err}, 32'd1);
      check("ld_left", {16'd0, steps_left}, 32'd10);
      check("ld_ready", {31'd0, req_ready}, 32'd1);
      pll_locked = 1'b1;
      repeat (4) tick();

      // reset while waiting for phase_done
      start_req(5'd7, 1'b0, 16'd20);
      wait_en_fall(100);
      step();
      rst = 1'b1;
      tick();
      check("mid_rst_outs", {cntsel, num_phase_shifts, updn, phase_en, busy,
                             done, err, steps_left}, 32'd0);
      check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("mid_rst_ready_after", {31'd0, req_ready}, 32'd1);
      repeat (4) tick();

      // phase_done never arrives
      start_req(5'd2, 1'b1, 16'd9);
      wait_en_fall(100);
`ifdef PLL_PHASE_TIMEOUT_EN
      repeat (15) step();
      check("to_c15_done", {31'd0, done}, 32'd0);
      step();
      check("to_c16_done", {31'd0, done}, 32'd1);
      check("to_err", {31'd0, err}, 32'd1);
      check("to_left", {16'd0, steps_left}, 32'd9);
`else
      repeat (40) step();
      check("hang_busy", {31'd0, busy}, 32'd1);
      check("hang_no_done", done_cnt, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
`endif
      repeat (4) tick();

      // random requests against the burst-list model
      pll_auto = 1'b1;
      for (int r = 0; r < 25; r++) begin
         logic [4:0]  cs;
         logic        u;
         logic [15:0] st;
         int          s;
         int          b;
         int          exp_q[$];
         cs = 5'($urandom_range(0, 31));
         u  = 1'($urandom_range(0, 1));
         st = 16'($urandom_range(0, 40));
         exp_q.delete();
         s = int'(st);
         while (s > 0) begin
            b = (s > MAXB) ? MAXB : s;
            exp_q.push_back(b);
            s -= b;
         end
         start_req(cs, u, st);
         wait_done(1500);
         check($sformatf("r%0d_nb", r), obs_n.size(), exp_q.size());
         for (int k = 0; k < exp_q.size() && k < obs_n.size(); k++) begin
            check($sformatf("r%0d_b%0d_n", r, k), {29'd0, obs_n[k]}, exp_q[k]);
            check($sformatf("r%0d_b%0d_cs", r, k), {27'd0, obs_cs[k]}, {27'd0, cs});
            check($sformatf("r%0d_b%0d_ud", r, k), {31'd0, obs_ud[k]}, {31'd0, u});
            if (k < obs_len.size())
               check($sformatf("r%0d_b%0d_len", r, k), obs_len[k], HOLD);
         end
         check($sformatf("r%0d_left", r), {16'd0, steps_left}, 32'd0);
         check($sformatf("r%0d_err", r), {31'd0, err}, 32'd0);
         check($sformatf("r%0d_busy", r), {31'd0, busy}, 32'd0);
         step();
         check($sformatf("r%0d_pulse", r), done_cnt, 1);
         repeat (4) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
